// File: rtl/int_ctrl_bamse.sv
// Interrupt controller for the io_bamse flag vector.
// Rising edges on the peripheral flags set sticky pending bits. The enabled
// pending bits are arbitrated lowest-index-first and presented on the
// Pacoblaze interrupt pin. The winning source ID is latched for firmware to
// read over the port bus. Firmware clears pending bits with a
// write-1-to-clear access.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no source latched; arbitrate the active bits
// ASSERT  | interrupt high, waiting for interrupt_ack
// SERVICE | acked; waiting for firmware to clear pending[src]
module int_ctrl_bamse #(
  parameter logic [7:0] ADDR_PEND = 8'h10,
  parameter logic [7:0] ADDR_SRC  = 8'h11,
  parameter logic [7:0] ADDR_CLR  = 8'h12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] int_flags,
  input  logic [7:0] int_enable,
  input  logic [7:0] address,
  input  logic [7:0] value_in,
  input  logic       wen,
  input  logic       ren,
  output logic [7:0] port_out,
  output logic       interrupt,
  input  logic       interrupt_ack
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [7:0] flag_d;
  logic [7:0] pending;
  logic [7:0] rise;
  logic [7:0] clr_mask;
  logic [7:0] active;
  logic [2:0] src, src_n;
  logic       valid, valid_n;
  logic       irq_n;
  logic [2:0] enc_idx;

  assign rise     = int_flags & ~flag_d;
  assign clr_mask = (wen && (address == ADDR_CLR)) ? value_in : 8'h00;
  assign active   = pending & int_enable;

  // Edge detect and sticky pending; a rise beats a same-cycle clear.
  always_ff @(posedge clk) begin
    flag_d <= int_flags;
    if (!rst) begin
      pending <= 8'h00;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
    end
  end

  // Lowest set index of the active vector wins.
  always_comb begin
    enc_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (active[i]) enc_idx = 3'(i);
    end
  end

  // State and registered FSM outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      interrupt <= 1'b0;
      valid     <= 1'b0;
      src       <= 3'd0;
    end else begin
      state     <= state_n;
      interrupt <= irq_n;
      valid     <= valid_n;
      src       <= src_n;
    end
  end

  // Next-state selection; ack takes priority over a withdrawn source.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (active != 8'h00) state_n = ASSERT;
      ASSERT: begin
        if (interrupt_ack)        state_n = SERVICE;
        else if (!active[src])    state_n = IDLE;
      end
      SERVICE: if (!pending[src]) state_n = IDLE;
      default:                    state_n = IDLE;
    endcase
  end

  // Next values of interrupt, valid and the latched source ID.
  always_comb begin
    irq_n   = interrupt;
    valid_n = valid;
    src_n   = src;
    case (state)
      IDLE: begin
        if (active != 8'h00) begin
          src_n   = enc_idx;
          valid_n = 1'b1;
          irq_n   = 1'b1;
        end
      end
      ASSERT: begin
        if (interrupt_ack) begin
          irq_n = 1'b0;
        end else if (!active[src]) begin
          irq_n   = 1'b0;
          valid_n = 1'b0;
        end
      end
      SERVICE: begin
        irq_n = 1'b0;
        if (!pending[src]) valid_n = 1'b0;
      end
      default: begin
        irq_n   = 1'b0;
        valid_n = 1'b0;
      end
    endcase
  end

  // Read port with one cycle of latency; idle cycles return zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      port_out <= 8'h00;
    end else if (ren && (address == ADDR_PEND)) begin
      port_out <= pending;
    end else if (ren && (address == ADDR_SRC)) begin
      port_out <= {valid, 4'b0000, src};
    end else begin
      port_out <= 8'h00;
    end
  end

endmodule

// File: tb/tb_int_ctrl_bamse.sv
// Bench for int_ctrl_bamse: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_int_ctrl_bamse;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] int_flags, int_enable, address, value_in;
  logic       wen, ren, interrupt_ack;
  logic [7:0] port_out;
  logic       interrupt;

  int_ctrl_bamse dut (
    .clk(clk), .rst(rst), .int_flags(int_flags), .int_enable(int_enable),
    .address(address), .value_in(value_in), .wen(wen), .ren(ren),
    .port_out(port_out), .interrupt(interrupt), .interrupt_ack(interrupt_ack)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: the controller's phase is implied by what it shows the CPU.
  // No source held -> arbitrating; interrupt high -> waiting for ack;
  // source held with interrupt low -> waiting for firmware to clear it.
  logic [7:0] m_pend, m_fd, m_port;
  logic [2:0] m_src;
  logic       m_valid, m_irq;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  // One clock: derive the model's next view from current inputs, clock the DUT.
  task automatic tick();
    logic [7:0] rise, clr, act, np, nport, nfd;
    logic [2:0] nsrc;
    logic       nvalid, nirq;
    nfd = int_flags;
    if (!rst) begin
      np = 8'h00; nport = 8'h00; nsrc = 3'd0; nvalid = 1'b0; nirq = 1'b0;
    end else begin
      rise = int_flags & ~m_fd;
      clr  = (wen && address == 8'h12) ? value_in : 8'h00;
      np   = (m_pend & ~clr) | rise;
      if (ren && address == 8'h10)      nport = m_pend;
      else if (ren && address == 8'h11) nport = {m_valid, 4'b0000, m_src};
      else                              nport = 8'h00;
      act = m_pend & int_enable;
      nsrc = m_src; nvalid = m_valid; nirq = m_irq;
      if (!m_valid) begin
        if (act != 8'h00) begin
          nsrc = lowest(act); nvalid = 1'b1; nirq = 1'b1;
        end
      end else if (m_irq) begin
        if (interrupt_ack) nirq = 1'b0;
        else if (!act[m_src]) begin
          nirq = 1'b0; nvalid = 1'b0;
        end
      end else if (!m_pend[m_src]) begin
        nvalid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_pend = np; m_fd = nfd; m_port = nport; m_src = nsrc;
    m_valid = nvalid; m_irq = nirq;
  endtask

  task automatic quiet();
    wen = 1'b0; ren = 1'b0; interrupt_ack = 1'b0;
    address = 8'h00; value_in = 8'h00;
  endtask

  task automatic rd(input logic [7:0] a);
    quiet(); ren = 1'b1; address = a; tick(); quiet();
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    quiet(); wen = 1'b1; address = a; value_in = d; tick(); quiet();
  endtask

  // Compare process: DUT against the model on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_irq", {7'b0, interrupt}, {7'b0, m_irq});
      chk("model_port_out", port_out, m_port);
    end
  end

  initial begin
    m_pend = 0; m_fd = 0; m_port = 0; m_src = 0; m_valid = 0; m_irq = 0;
    quiet();
    rst = 1'b0; int_flags = 8'h04; int_enable = 8'hFF;
    @(posedge clk); #1;
    tick(); tick();
    chk_en = 1'b1;
    chk("reset_irq", {7'b0, interrupt}, 8'h00);
    chk("reset_port", port_out, 8'h00);

    // 1: flag already high across reset release produces nothing
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t1_irq", {7'b0, interrupt}, 8'h00);
    end
    rd(8'h10);
    chk("t1_pend", port_out, 8'h00);
    int_flags = 8'h00; tick();

    // 2: single source, full ack/clear cycle
    int_enable = 8'h28;
    int_flags = 8'h20; tick();
    int_flags = 8'h00;
    rd(8'h10);
    chk("t2_pend", port_out, 8'h20);
    chk("t2_irq_up", {7'b0, interrupt}, 8'h01);
    rd(8'h11);
    chk("t2_src", port_out, 8'h85);
    m_pend = m_pend;
    tick(); tick();
    chk("t2_irq_held", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1'b1; tick(); quiet();
    chk("t2_irq_ack", {7'b0, interrupt}, 8'h00);
    wr(8'h12, 8'h20);
    tick();
    rd(8'h11);
    chk("t2_src_done", port_out, 8'h05);

    // 3: simultaneous rises, lowest index served first
    int_enable = 8'h0A;
    int_flags = 8'h0A; tick();
    int_flags = 8'h00; tick();
    chk("t3_irq1", {7'b0, interrupt}, 8'h01);
    rd(8'h11);
    chk("t3_src1", port_out, 8'h81);
    interrupt_ack = 1'b1; tick(); quiet();
    wr(8'h12, 8'h02);
    tick(); tick();
    chk("t3_irq2", {7'b0, interrupt}, 8'h01);
    rd(8'h11);
    chk("t3_src3", port_out, 8'h83);
    interrupt_ack = 1'b1; tick(); quiet();
    wr(8'h12, 8'h08);
    tick(); tick();

    // 4: rise beats a same-cycle clear
    int_enable = 8'h00;
    int_flags = 8'h08; tick();
    int_flags = 8'h00; tick();
    int_flags = 8'h08; wr(8'h12, 8'h08);
    rd(8'h10);
    chk("t4_pend_kept", port_out, 8'h08);
    wr(8'h12, 8'h08);
    int_flags = 8'h00;
    rd(8'h10);
    chk("t4_pend_clr", port_out, 8'h00);

    // 5: source disabled before ack withdraws the request
    int_enable = 8'h04;
    int_flags = 8'h04; tick();
    int_flags = 8'h00; tick();
    chk("t5_irq_up", {7'b0, interrupt}, 8'h01);
    int_enable = 8'h00; tick();
    chk("t5_irq_drop", {7'b0, interrupt}, 8'h00);
    rd(8'h11);
    chk("t5_src", port_out, 8'h02);
    rd(8'h10);
    chk("t5_pend", port_out, 8'h04);
    wr(8'h12, 8'h04);

    // 6: reset during service
    int_enable = 8'h01;
    int_flags = 8'h01; tick();
    int_flags = 8'h00; tick();
    chk("t6_irq_up", {7'b0, interrupt}, 8'h01);
    interrupt_ack = 1'b1; tick(); quiet();
    rst = 1'b0; ren = 1'b1; address = 8'h10; tick(); quiet();
    rst = 1'b1;
    chk("t6_irq_rst", {7'b0, interrupt}, 8'h00);
    chk("t6_port_rst", port_out, 8'h00);
    rd(8'h10);
    chk("t6_pend_rst", port_out, 8'h00);
    interrupt_ack = 1'b1; tick(); quiet(); tick();
    chk("t6_ack_ignored", {7'b0, interrupt}, 8'h00);

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      quiet();
      rst = ($urandom_range(0, 299) != 0);
      int_flags = int_flags ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
      if ($urandom_range(0, 15) == 0) int_enable = 8'($urandom);
      interrupt_ack = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: address = 8'h10;
        1: address = 8'h11;
        2: address = 8'h12;
        default: address = 8'($urandom);
      endcase
      value_in = 8'($urandom);
      ren = ($urandom_range(0, 1) == 1);
      wen = ($urandom_range(0, 3) == 0);
      tick();
    end

    quiet(); rst = 1'b1;
    @(negedge clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
